// File: rtl/cvbs_pkg.sv
// Shared codes, state/colour types and the quarter-wave sine table for the
// NTSC-M composite encoder.
package cvbs_pkg;

  localparam logic [11:0] SYNC_CODE  = 12'd0;
  localparam logic [11:0] BLANK_CODE = 12'd1170;
  localparam logic [11:0] BLACK_CODE = 12'd1389;
  localparam logic [11:0] WHITE_CODE = 12'd4095;
  localparam int          BURST_AMP  = 585;
  localparam logic [31:0] PHASE_INC  = 32'd207078536;

  typedef enum logic [2:0] {SYNC, BREEZE, BURST, PORCH, ACTIVE, FRONT} cvbs_state_t;

  typedef struct packed {
    logic        [7:0] y;
    logic signed [8:0] u;
    logic signed [8:0] v;
  } yuv_t;

  // round(2047*sin(k*pi/128)) for k = 0..64
  localparam logic [10:0] QSIN [0:64] = '{
    11'd0,    11'd50,   11'd100,  11'd151,  11'd201,  11'd251,  11'd300,  11'd350,
    11'd399,  11'd449,  11'd497,  11'd546,  11'd594,  11'd642,  11'd690,  11'd737,
    11'd783,  11'd830,  11'd875,  11'd920,  11'd965,  11'd1009, 11'd1052, 11'd1095,
    11'd1137, 11'd1179, 11'd1219, 11'd1259, 11'd1299, 11'd1337, 11'd1375, 11'd1411,
    11'd1447, 11'd1483, 11'd1517, 11'd1550, 11'd1582, 11'd1614, 11'd1644, 11'd1674,
    11'd1702, 11'd1729, 11'd1756, 11'd1781, 11'd1805, 11'd1828, 11'd1850, 11'd1871,
    11'd1891, 11'd1910, 11'd1927, 11'd1944, 11'd1959, 11'd1973, 11'd1986, 11'd1997,
    11'd2008, 11'd2017, 11'd2025, 11'd2032, 11'd2037, 11'd2041, 11'd2045, 11'd2046,
    11'd2047
  };

  // Full-cycle 12-bit signed sine from an 8-bit phase; cos(x) = sin_lut(x + 64).
  function automatic logic signed [11:0] sin_lut(input logic [7:0] idx);
    logic [6:0]  k;
    logic [11:0] mag;
    k   = idx[6] ? (7'd64 - {1'b0, idx[5:0]}) : {1'b0, idx[5:0]};
    mag = {1'b0, QSIN[k]};
    return idx[7] ? -$signed(mag) : $signed(mag);
  endfunction

endpackage

// File: rtl/cvbs_line_timer.sv
// Horizontal/vertical sample counters and the per-sample timing state machine.
// state is the registered decode of the current (h_cnt, v_cnt) position.
module cvbs_line_timer
  import cvbs_pkg::*;
#(
  parameter int LINE_LEN         = 4720,
  parameter int HSYNC_LEN        = 349,
  parameter int BURST_START      = 393,
  parameter int BURST_LEN        = 187,
  parameter int ACTIVE_START     = 700,
  parameter int PIXEL_DIV        = 6,
  parameter int H_PIXELS         = 640,
  parameter int FRAME_LINES      = 262,
  parameter int VSYNC_FIRST      = 3,
  parameter int ACTIVE_FIRST     = 22,
  parameter int BURST_FIRST_LINE = 9
) (
  input  logic        clk,
  input  logic        rst,
  output cvbs_state_t state,
  output logic        pix_slot_start,
  output logic        line_start,
  output logic        frame_start
);

  localparam int HW = $clog2(LINE_LEN);
  localparam int VW = $clog2(FRAME_LINES);
  localparam int PW = (PIXEL_DIV > 1) ? $clog2(PIXEL_DIV) : 1;

  localparam logic [HW-1:0] H_LAST        = HW'(LINE_LEN - 1);
  localparam logic [HW-1:0] H_SYNC_END    = HW'(HSYNC_LEN);
  localparam logic [HW-1:0] H_BROAD_END   = HW'(LINE_LEN - HSYNC_LEN);
  localparam logic [HW-1:0] H_BURST_FIRST = HW'(BURST_START);
  localparam logic [HW-1:0] H_BURST_END   = HW'(BURST_START + BURST_LEN);
  localparam logic [HW-1:0] H_ACT_FIRST   = HW'(ACTIVE_START);
  localparam logic [HW-1:0] H_ACT_END     = HW'(ACTIVE_START + H_PIXELS * PIXEL_DIV);
  localparam logic [VW-1:0] V_LAST        = VW'(FRAME_LINES - 1);
  localparam logic [VW-1:0] V_BROAD_FIRST = VW'(VSYNC_FIRST);
  localparam logic [VW-1:0] V_BROAD_LAST  = VW'(VSYNC_FIRST + 2);
  localparam logic [VW-1:0] V_BURST_FIRST = VW'(BURST_FIRST_LINE);
  localparam logic [VW-1:0] V_ACT_FIRST   = VW'(ACTIVE_FIRST);
  localparam logic [PW-1:0] P_LAST        = PW'(PIXEL_DIV - 1);

  logic [HW-1:0] h_cnt, h_nxt;
  logic [VW-1:0] v_cnt, v_nxt;
  logic [PW-1:0] pix_ph, pix_ph_nxt;
  cvbs_state_t   state_nxt;
  logic          broad;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt  <= '0;
      v_cnt  <= '0;
      pix_ph <= '0;
      state  <= SYNC;
    end else begin
      h_cnt  <= h_nxt;
      v_cnt  <= v_nxt;
      pix_ph <= pix_ph_nxt;
      state  <= state_nxt;
    end
  end

  always_comb begin
    h_nxt = h_cnt + 1'b1;
    v_nxt = v_cnt;
    if (h_cnt == H_LAST) begin
      h_nxt = '0;
      v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end
    broad     = (v_nxt >= V_BROAD_FIRST) && (v_nxt <= V_BROAD_LAST);
    state_nxt = FRONT;
    if (broad)                     state_nxt = (h_nxt < H_BROAD_END) ? SYNC : FRONT;
    else if (h_nxt < H_SYNC_END)   state_nxt = SYNC;
    else if (h_nxt < H_BURST_FIRST) state_nxt = BREEZE;
    else if (h_nxt < H_BURST_END)  state_nxt = (v_nxt >= V_BURST_FIRST) ? BURST : BREEZE;
    else if (h_nxt < H_ACT_FIRST)  state_nxt = PORCH;
    else if (h_nxt < H_ACT_END)    state_nxt = (v_nxt >= V_ACT_FIRST) ? ACTIVE : PORCH;
    // pix_ph counts samples within a pixel slot, restarting on entry to ACTIVE
    pix_ph_nxt = '0;
    if (state_nxt == ACTIVE && state == ACTIVE && pix_ph != P_LAST) pix_ph_nxt = pix_ph + 1'b1;
  end

  assign pix_slot_start = (state == ACTIVE) && (pix_ph == '0);
  assign line_start     = (h_cnt == '0);
  assign frame_start    = (h_cnt == '0) && (v_cnt == '0);

endmodule

// File: rtl/composite_encoder.sv
// NTSC-M 240p composite encoder: pixel handshake, RGB->YUV, QAM chroma and
// sync/blank/burst insertion. Colour is enabled by defining CVBS_CHROMA_EN.
module composite_encoder
  import cvbs_pkg::*;
#(
  parameter int LINE_LEN         = 4720,
  parameter int HSYNC_LEN        = 349,
  parameter int BURST_START      = 393,
  parameter int BURST_LEN        = 187,
  parameter int ACTIVE_START     = 700,
  parameter int PIXEL_DIV        = 6,
  parameter int H_PIXELS         = 640,
  parameter int FRAME_LINES      = 262,
  parameter int VSYNC_FIRST      = 3,
  parameter int ACTIVE_FIRST     = 22,
  parameter int BURST_FIRST_LINE = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] rgb_in,
  input  logic        pix_valid,
  output logic        pix_ready,
  output logic        line_start,
  output logic        frame_start,
  output logic        underflow,
  output logic [11:0] cvbs_out
);

  cvbs_state_t t_state, s1_state, s2_state, s3_state;
  logic        t_slot, t_ls, t_fs;
  logic        s1_ls, s1_fs, s2_ls, s2_fs, s3_ls, s3_fs;
  logic [23:0] pix_q;
  logic [15:0] y_sum, y_acc;
  logic [7:0]  y_c;
  logic [11:0] luma_c, s3_luma, cvbs_nxt;

  cvbs_line_timer #(
    .LINE_LEN(LINE_LEN), .HSYNC_LEN(HSYNC_LEN), .BURST_START(BURST_START),
    .BURST_LEN(BURST_LEN), .ACTIVE_START(ACTIVE_START), .PIXEL_DIV(PIXEL_DIV),
    .H_PIXELS(H_PIXELS), .FRAME_LINES(FRAME_LINES), .VSYNC_FIRST(VSYNC_FIRST),
    .ACTIVE_FIRST(ACTIVE_FIRST), .BURST_FIRST_LINE(BURST_FIRST_LINE)
  ) u_timer (
    .clk(clk), .rst(rst), .state(t_state), .pix_slot_start(t_slot),
    .line_start(t_ls), .frame_start(t_fs)
  );

  // Handshake: pix_ready pulses on the first sample of each pixel slot and is
  // never stalled; a pixel transfers when pix_valid is high in that cycle,
  // otherwise the slot is black and underflow latches.
  assign pix_ready = t_slot;

  assign y_sum  = 16'd77 * {8'd0, pix_q[23:16]} + 16'd150 * {8'd0, pix_q[15:8]}
                + 16'd29 * {8'd0, pix_q[7:0]};
  assign y_c    = 8'(y_acc >> 8);
  assign luma_c = BLACK_CODE + 12'(({12'd0, y_c} * 20'd2717) >> 8);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {s1_state, s2_state, s3_state} <= {FRONT, FRONT, FRONT};
      {s1_ls, s1_fs, s2_ls, s2_fs, s3_ls, s3_fs} <= '0;
      pix_q       <= '0;
      underflow   <= 1'b0;
      y_acc       <= '0;
      s3_luma     <= BLACK_CODE;
      cvbs_out    <= BLANK_CODE;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      s1_state <= t_state;  s1_ls <= t_ls;  s1_fs <= t_fs;
      s2_state <= s1_state; s2_ls <= s1_ls; s2_fs <= s1_fs;
      s3_state <= s2_state; s3_ls <= s2_ls; s3_fs <= s2_fs;
      if (t_slot) begin
        pix_q <= pix_valid ? rgb_in : 24'd0;
        if (!pix_valid) underflow <= 1'b1;
      end
      y_acc       <= y_sum;
      s3_luma     <= luma_c;
      cvbs_out    <= cvbs_nxt;
      line_start  <= s3_ls;
      frame_start <= s3_fs;
    end
  end

`ifdef CVBS_CHROMA_EN
  logic [31:0]        phase;
  logic signed [17:0] r_s, g_s, b_s, u_sum, v_sum, u_acc, v_acc;
  yuv_t               yuv_c, s3_yuv;
  logic signed [11:0] sin_v, cos_v;
  logic signed [21:0] mix;
  logic signed [22:0] burst_mix;
  logic signed [14:0] total;
  logic [11:0]        burst_code, active_code;

  assign r_s   = $signed({10'd0, pix_q[23:16]});
  assign g_s   = $signed({10'd0, pix_q[15:8]});
  assign b_s   = $signed({10'd0, pix_q[7:0]});
  assign u_sum = 18'sd112 * b_s - 18'sd38 * r_s - 18'sd74 * g_s;
  assign v_sum = 18'sd157 * r_s - 18'sd132 * g_s - 18'sd25 * b_s;

  always_comb begin
    yuv_c.y = y_c;
    yuv_c.u = 9'(u_acc >>> 8);
    yuv_c.v = 9'(v_acc >>> 8);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase  <= '0;
      u_acc  <= '0;
      v_acc  <= '0;
      s3_yuv <= '0;
    end else begin
      phase  <= phase + PHASE_INC;
      u_acc  <= u_sum;
      v_acc  <= v_sum;
      s3_yuv <= yuv_c;
    end
  end

  assign sin_v      = sin_lut(phase[31:24]);
  assign cos_v      = sin_lut(phase[31:24] + 8'd64);
  assign mix        = 22'(s3_yuv.u) * 22'(sin_v) + 22'(s3_yuv.v) * 22'(cos_v);
  assign burst_mix  = -(23'(sin_v)) * 23'(BURST_AMP);
  assign burst_code = 12'($signed({1'b0, BLANK_CODE}) + 13'(burst_mix >>> 11));
  assign total      = $signed({3'b000, s3_luma}) + 15'(mix >>> 8);

  // Active video is the only path that can leave the DAC range
  always_comb begin
    active_code = total[11:0];
    if (total < 0)                                  active_code = SYNC_CODE;
    else if (total > $signed({3'b000, WHITE_CODE})) active_code = WHITE_CODE;
  end
`else
  logic [11:0] burst_code, active_code;
  assign burst_code  = BLANK_CODE;
  assign active_code = s3_luma;
`endif

  always_comb begin
    cvbs_nxt = BLANK_CODE;
    case (s3_state)
      SYNC:    cvbs_nxt = SYNC_CODE;
      BURST:   cvbs_nxt = burst_code;
      ACTIVE:  cvbs_nxt = active_code;
      default: cvbs_nxt = BLANK_CODE;
    endcase
  end

endmodule

// File: tb/tb_composite_encoder.sv
// Scoreboarded bench for composite_encoder on a reduced line/frame geometry;
// the reference model derives every sample from its absolute sample index.
module tb_composite_encoder;

  localparam int L = 200, HS = 15, BS = 18, BL = 30, AS = 60, DIV = 6, HP = 20;
  localparam int F = 30, VS = 3, AF = 12, NB = 9;
  localparam int BLANK = 1170, BLACK = 1389, AMP = 585;
  localparam logic [31:0] INC = 32'd207078536;
  localparam real PI = 3.141592653589793;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [23:0] rgb_in = '0;
  logic        pix_valid = 1'b0;
  logic        pix_ready, line_start, frame_start, underflow;
  logic [11:0] cvbs_out;

  int n_cmp = 0, n_bad = 0;
  int n = 0, c = 0, rdy_cnt = 0;
  bit running = 1'b0, uflag = 1'b0;
  int cur_r = 0, cur_g = 0, cur_b = 0;
  logic [14:0] exp_q[$];

  composite_encoder #(
    .LINE_LEN(L), .HSYNC_LEN(HS), .BURST_START(BS), .BURST_LEN(BL),
    .ACTIVE_START(AS), .PIXEL_DIV(DIV), .H_PIXELS(HP), .FRAME_LINES(F),
    .VSYNC_FIRST(VS), .ACTIVE_FIRST(AF), .BURST_FIRST_LINE(NB)
  ) dut (
    .clk(clk), .rst(rst), .rgb_in(rgb_in), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .line_start(line_start), .frame_start(frame_start),
    .underflow(underflow), .cvbs_out(cvbs_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp, input int tol);
    n_cmp++;
    if (act > exp + tol || act < exp - tol) begin
      n_bad++;
      $display("FAIL %s @sample %0d: got %0d expected %0d (tol %0d)", name, n, act, exp, tol);
    end
  endtask

  function automatic int sin12(input logic [31:0] ph);
    return int'(2047.0 * $sin(2.0 * PI * real'(int'(ph[31:24])) / 256.0));
  endfunction

  function automatic int cos12(input logic [31:0] ph);
    return int'(2047.0 * $cos(2.0 * PI * real'(int'(ph[31:24])) / 256.0));
  endfunction

  task automatic check_reset_outputs();
    check("rst_cvbs", int'(cvbs_out), BLANK, 0);
    check("rst_pix_ready", int'(pix_ready), 0, 0);
    check("rst_line_start", int'(line_start), 0, 0);
    check("rst_frame_start", int'(frame_start), 0, 0);
    check("rst_underflow", int'(underflow), 0, 0);
  endtask

  // Driver: fresh random pixel offer every cycle, mostly valid
  always @(posedge clk) begin
    #1;
    pix_valid = ($urandom_range(0, 15) != 0);
    case ($urandom_range(0, 5))
      0:       rgb_in = 24'hFFFFFF;
      1:       rgb_in = 24'h0000FF;
      2:       rgb_in = 24'h000000;
      default: rgb_in = 24'($urandom);
    endcase
  end

  // Reference model: expected output of sample n, queued for the monitor
  always @(negedge clk) if (running) begin
    int h, ln, code, tol, y, u, v, luma, chroma;
    bit slot;
    logic [31:0] ph;
    logic [14:0] ent;
    h    = n % L;
    ln   = (n / L) % F;
    ph   = 32'(n + 3) * INC;
    slot = 1'b0;
    tol  = 0;
    code = BLANK;
    if (ln >= VS && ln < VS + 3) begin
      code = (h < L - HS) ? 0 : BLANK;
    end else if (h < HS) begin
      code = 0;
    end else if (h >= BS && h < BS + BL && ln >= NB) begin
`ifdef CVBS_CHROMA_EN
      code = BLANK + ((-sin12(ph) * AMP) >>> 11);
      tol  = 2;
`endif
    end else if (h >= AS && h < AS + HP * DIV && ln >= AF) begin
      if ((h - AS) % DIV == 0) begin
        slot  = 1'b1;
        cur_r = pix_valid ? int'(rgb_in[23:16]) : 0;
        cur_g = pix_valid ? int'(rgb_in[15:8])  : 0;
        cur_b = pix_valid ? int'(rgb_in[7:0])   : 0;
      end
      y    = (77 * cur_r + 150 * cur_g + 29 * cur_b) >> 8;
      luma = BLACK + ((y * 2717) >> 8);
      code = luma;
`ifdef CVBS_CHROMA_EN
      u      = (-38 * cur_r - 74 * cur_g + 112 * cur_b) >>> 8;
      v      = (157 * cur_r - 132 * cur_g - 25 * cur_b) >>> 8;
      chroma = (u * sin12(ph) + v * cos12(ph)) >>> 8;
      code   = luma + chroma;
      if (code < 0) code = 0;
      if (code > 4095) code = 4095;
      tol = 2;
`endif
    end
    check("pix_ready", int'(pix_ready), int'(slot), 0);
    check("underflow", int'(underflow), int'(uflag), 0);
    if (slot && !pix_valid) uflag = 1'b1;
    if (pix_ready && n < L * F) rdy_cnt++;
    ent[11:0] = code[11:0];
    ent[12]   = (h == 0);
    ent[13]   = (h == 0) && (ln == 0);
    ent[14]   = (tol != 0);
    exp_q.push_back(ent);
    n++;
  end

  // Monitor: pipeline still flushing for 4 clocks, then one sample per clock
  always @(negedge clk) if (running) begin
    logic [14:0] e;
    if (c < 4) begin
      check("flush_cvbs", int'(cvbs_out), BLANK, 0);
      check("flush_frame_start", int'(frame_start), 0, 0);
    end else if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL queue_empty @sample %0d: got no expected entry, required one", n);
    end else begin
      e = exp_q.pop_front();
      check("cvbs_out", int'(cvbs_out), int'(e[11:0]), e[14] ? 2 : 0);
      check("line_start", int'(line_start), int'(e[12]), 0);
      check("frame_start", int'(frame_start), int'(e[13]), 0);
    end
    c++;
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #2 rst = 1'b1;
    running = 1'b1;
    repeat (L * F + 2300) @(posedge clk);
    // Reset in the middle of a line, then restart from line 0 sample 0
    #2 rst = 1'b0;
    running = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs();
    check("transfers_per_frame", rdy_cnt, HP * (F - AF), 0);
    exp_q.delete();
    n = 0;
    c = 0;
    uflag = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    running = 1'b1;
    repeat (3000) @(posedge clk);
    #2 running = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
